// File: rtl/la_ioring_pkg.sv
// Shared types for the IO ring power sequencer: FSM state encoding, ring bit
// positions and the per-state ring level. FAULT is OFF with the fault flag set,
// which keeps the state register at 3 bits.
package la_ioring_pkg;

    typedef enum logic [2:0] {
        OFF     = 3'd0,
        WAIT_PG = 3'd1,
        BIAS    = 3'd2,
        ISO     = 3'd3,
        DRV     = 3'd4,
        ON      = 3'd5,
        DN_DRV  = 3'd6,
        DN_ISO  = 3'd7
    } state_e;

    localparam int BIAS_EN_BIT = 0;
    localparam int ISO_REL_BIT = 1;
    localparam int DRV_EN_BIT  = 2;
    localparam int RING_OK_BIT = 3;

    // Low nibble of the ring bus driven while sitting in a given state.
    function automatic logic [3:0] ring_level(input state_e s);
        logic [3:0] r;
        r = 4'b0000;
        case (s)
            BIAS, DN_ISO: r[BIAS_EN_BIT] = 1'b1;
            ISO, DN_DRV: begin
                r[BIAS_EN_BIT] = 1'b1;
                r[ISO_REL_BIT] = 1'b1;
            end
            DRV: begin
                r[BIAS_EN_BIT] = 1'b1;
                r[ISO_REL_BIT] = 1'b1;
                r[DRV_EN_BIT]  = 1'b1;
            end
            ON: r = 4'b1111;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/la_ioring_sync.sv
// Power-good synchronizer: 2-flop sync of the asynchronous pg input.
// Latency: 2 cycles; with LA_IORING_SEQ_DEBOUNCE_EN a 16-cycle stability filter follows (2+16).
// Backpressure: none, free-running level path.
module la_ioring_sync (
    input  logic clk,
    input  logic reset,
    input  logic pg_i,
    output logic pg_s_o
);

    logic ff1_q;
    logic ff2_q;

    // Two-flop metastability synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= pg_i;
            ff2_q <= ff1_q;
        end
    end

`ifdef LA_IORING_SEQ_DEBOUNCE_EN
    logic       filt_q;
    logic       filt_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Count consecutive cycles the synced value disagrees with the filtered
    // value; adopt it on the 16th, restart the count whenever they agree.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 4'd0;
        if (ff2_q != filt_q) begin
            if (cnt_q == 4'hF) begin
                filt_d = ff2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Debounce filter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pg_s_o = filt_q;
`else
    assign pg_s_o = ff2_q;
`endif

endmodule

// File: rtl/la_ioring_seq.sv
// IO ring power sequencer: bias -> isolation release -> driver enable, reverse on teardown.
// Latency: all outputs registered; each timed step lasts dly+1 cycles; pg seen 2 (or 2+16 with LA_IORING_SEQ_DEBOUNCE_EN) cycles late.
// Backpressure: none; en/pg are levels, teardown always runs to completion.
module la_ioring_seq
    import la_ioring_pkg::*;
#(
    parameter int RINGW = 8,
    parameter int DLYW  = 16,
    parameter int TOW   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pg,
    input  logic [DLYW-1:0]  dly,
    output logic [RINGW-1:0] ioring,
    output logic             ready,
    output logic             fault,
    output logic [2:0]       state
);

    // Timeout fires on the cycle the counter would step from all-ones-minus-one to all-ones.
    localparam logic [TOW-1:0] TO_MAX  = '1;
    localparam logic [TOW-1:0] TO_LAST = {{(TOW-1){1'b1}}, 1'b0};

    logic             pg_s;
    state_e           state_q,   state_d;
    logic             fault_q,   fault_d;
    logic [DLYW-1:0]  dly_cnt_q, dly_cnt_d;
    logic [TOW-1:0]   to_cnt_q,  to_cnt_d;
    logic [RINGW-1:0] ioring_q,  ioring_d;
    logic             ready_q,   ready_d;
    logic             dly_done;

    la_ioring_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .pg_i   (pg),
        .pg_s_o (pg_s)
    );

    assign dly_done = (dly_cnt_q == '0);

    // State and output registers; reset drops the ring at once, no teardown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= OFF;
            fault_q   <= 1'b0;
            dly_cnt_q <= '0;
            to_cnt_q  <= '0;
            ioring_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fault_q   <= fault_d;
            dly_cnt_q <= dly_cnt_d;
            to_cnt_q  <= to_cnt_d;
            ioring_q  <= ioring_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic: pg loss outranks en drop, teardown picks up at the current ring level.
    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        dly_cnt_d = dly_cnt_q;
        to_cnt_d  = to_cnt_q;
        case (state_q)
            OFF: begin
                if (fault_q) begin
                    if (!en) fault_d = 1'b0;
                end else if (en) begin
                    state_d  = WAIT_PG;
                    to_cnt_d = '0;
                end
            end
            WAIT_PG: begin
                if (!en) begin
                    state_d = OFF;
                end else if (pg_s) begin
                    state_d   = BIAS;
                    dly_cnt_d = dly;
                end else if (to_cnt_q == TO_LAST) begin
                    state_d  = OFF;
                    fault_d  = 1'b1;
                    to_cnt_d = TO_MAX;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            BIAS, ISO, DRV: begin
                if (!pg_s || !en) begin
                    state_d   = (state_q == BIAS) ? DN_ISO : DN_DRV;
                    dly_cnt_d = dly;
                    if (!pg_s) fault_d = 1'b1;
                end else if (dly_done) begin
                    state_d   = (state_q == BIAS) ? ISO : ((state_q == ISO) ? DRV : ON);
                    dly_cnt_d = dly;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end
            ON: begin
                if (!pg_s || !en) begin
                    state_d   = DN_DRV;
                    dly_cnt_d = dly;
                    if (!pg_s) fault_d = 1'b1;
                end
            end
            DN_DRV: begin
                if (dly_done) begin
                    state_d   = DN_ISO;
                    dly_cnt_d = dly;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end
            DN_ISO: begin
                if (dly_done) begin
                    state_d = OFF;
                end else begin
                    dly_cnt_d = dly_cnt_q - 1'b1;
                end
            end
            default: state_d = OFF;
        endcase
    end

    // Output decode from the next state so the registered ring tracks the state register.
    always_comb begin
        ioring_d      = '0;
        ioring_d[3:0] = ring_level(state_d);
        ready_d       = (state_d == ON);
    end

    assign ioring = ioring_q;
    assign ready  = ready_q;
    assign fault  = fault_q;
    assign state  = state_q;

endmodule
